// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multi-cycle instruction fetch stage feeding the control unit.
// Holds the program counter, the instruction register and the link register,
// and runs a req/ack handshake with instruction memory.
// Optional feature: define IF_TIMEOUT_EN to abandon a fetch that has seen no
// im_ack after TIMEOUT wait cycles. The IR is then loaded with NOP_INST and
// the sticky fetch_err flag is raised.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [1:0]  pc_update_sel,
  input  logic        ir_write,
  input  logic [31:0] imm32,
  input  logic [31:0] f_reg,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] p_reg,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        fetch_busy,
  output logic        inst_valid,
  output logic        misalign_err,
  output logic        fetch_err
);

  // Update selector codes; code 2'd3 falls through to a sequential step.
  localparam logic [1:0] PC_STEP = 2'd0;
  localparam logic [1:0] PC_JP_R = 2'd1;
  localparam logic [1:0] PC_JP_F = 2'd2;

  typedef enum logic {F_IDLE, F_WAIT} state_t;

  state_t      state, state_next;
  logic        first_launch;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        launch;
  logic        load;
  logic        timeout_hit;

  assign launch = (state == F_IDLE) && ir_write;
  assign load   = (state == F_WAIT) && im_ack;

  // Next fetch address before alignment; the first launch after reset always uses RESET_PC.
  always_comb begin
    raw_target = pc + 32'd4;
    if (first_launch) begin
      raw_target = RESET_PC;
    end else if (!pc_write) begin
      raw_target = pc;
    end else begin
      case (pc_update_sel)
        PC_STEP: raw_target = pc + 32'd4;
        PC_JP_R: raw_target = pc + imm32;
        PC_JP_F: raw_target = f_reg & ~32'h1;
        default: raw_target = pc + 32'd4;
      endcase
    end
  end

  assign target = {raw_target[31:2], 2'b00};

`ifdef IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // The abort fires on the wait cycle that would bring the counter to TIMEOUT; an ack in that cycle wins.
  assign timeout_hit = (state == F_WAIT) && !im_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Count F_WAIT cycles without an ack, restarting at every launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (launch) begin
      wait_cnt <= '0;
    end else if ((state == F_WAIT) && !im_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky record that at least one fetch was abandoned since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else if (timeout_hit) begin
      fetch_err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State register; reset abandons any outstanding fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= F_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: launch from idle, return to idle on ack or abort.
  always_comb begin
    state_next = state;
    case (state)
      F_IDLE: if (ir_write) state_next = F_WAIT;
      F_WAIT: if (im_ack || timeout_hit) state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  // Fetch datapath: PC, link and address at launch; IR and valid pulse at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      p_reg        <= 32'h0;
      ir           <= NOP_INST;
      im_addr      <= 32'h0;
      im_req       <= 1'b0;
      inst_valid   <= 1'b0;
      misalign_err <= 1'b0;
      first_launch <= 1'b1;
    end else begin
      inst_valid <= 1'b0;
      if (launch) begin
        pc           <= target;
        p_reg        <= target + 32'd4;
        im_addr      <= target;
        im_req       <= 1'b1;
        first_launch <= 1'b0;
        if (raw_target[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end
      end
      if (load) begin
        ir         <= im_rdata;
        im_req     <= 1'b0;
        inst_valid <= 1'b1;
      end else if (timeout_hit) begin
        ir         <= NOP_INST;
        im_req     <= 1'b0;
        inst_valid <= 1'b1;
      end
    end
  end

  assign fetch_busy = (state == F_WAIT);

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: self-checking bench for inst_fetch_unit.
// Directed table of fetches, hand-written reset/ack corner cases, optional
// timeout cases (IF_TIMEOUT_EN), then random traffic against a reference model.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          TIMEOUT  = 16;
  localparam logic [1:0]  SEL_STEP = 2'd0;
  localparam logic [1:0]  SEL_JP_R = 2'd1;
  localparam logic [1:0]  SEL_JP_F = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [1:0]  pc_update_sel;
  logic        ir_write;
  logic [31:0] imm32;
  logic [31:0] f_reg;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] pc;
  logic [31:0] p_reg;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        fetch_busy;
  logic        inst_valid;
  logic        misalign_err;
  logic        fetch_err;

  int total_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic        pw;
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] freg;
    int          wait_n;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[11];

  inst_fetch_unit #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pc_write),
    .pc_update_sel(pc_update_sel),
    .ir_write     (ir_write),
    .imm32        (imm32),
    .f_reg        (f_reg),
    .im_req       (im_req),
    .im_addr      (im_addr),
    .im_ack       (im_ack),
    .im_rdata     (im_rdata),
    .pc           (pc),
    .p_reg        (p_reg),
    .ir           (ir),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .fetch_busy   (fetch_busy),
    .inst_valid   (inst_valid),
    .misalign_err (misalign_err),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  task automatic clear_inputs();
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_update_sel = SEL_STEP;
    imm32         = 32'h0;
    f_reg         = 32'h0;
    im_ack        = 1'b0;
    im_rdata      = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete fetch: launch, wait_n ack-less cycles with ignored strobes, then ack.
  task automatic apply_vector(input vec_t v, input int idx);
    logic [31:0] r;
    r = v.rdata;
    @(negedge clk);
    ir_write      = 1'b1;
    pc_write      = v.pw;
    pc_update_sel = v.sel;
    imm32         = v.imm;
    f_reg         = v.freg;
    im_ack        = 1'b0;
    @(negedge clk);
    ir_write = 1'b0;
    pc_write = 1'b0;
    check($sformatf("v%0d im_addr", idx), im_addr, v.exp_addr);
    check($sformatf("v%0d pc", idx), pc, v.exp_addr);
    check($sformatf("v%0d p_reg", idx), p_reg, v.exp_addr + 32'd4);
    check_bit($sformatf("v%0d im_req", idx), im_req, 1'b1);
    check_bit($sformatf("v%0d fetch_busy", idx), fetch_busy, 1'b1);
    check_bit($sformatf("v%0d misalign_err", idx), misalign_err, v.exp_mis);
    for (int i = 0; i < v.wait_n; i++) begin
      ir_write      = 1'b1;
      pc_write      = 1'b1;
      pc_update_sel = SEL_JP_F;
      f_reg         = 32'h0000_0F00;
      @(negedge clk);
      check_bit($sformatf("v%0d wait%0d im_req", idx, i), im_req, 1'b1);
      check($sformatf("v%0d wait%0d im_addr", idx, i), im_addr, v.exp_addr);
      check($sformatf("v%0d wait%0d pc", idx, i), pc, v.exp_addr);
    end
    ir_write = 1'b0;
    pc_write = 1'b0;
    im_ack   = 1'b1;
    im_rdata = v.rdata;
    @(negedge clk);
    im_ack = 1'b0;
    check($sformatf("v%0d ir", idx), ir, v.rdata);
    check_bit($sformatf("v%0d inst_valid", idx), inst_valid, 1'b1);
    check_bit($sformatf("v%0d im_req after ack", idx), im_req, 1'b0);
    check_bit($sformatf("v%0d busy after ack", idx), fetch_busy, 1'b0);
    check($sformatf("v%0d opcode", idx), {25'b0, opcode}, {25'b0, r[6:0]});
    check($sformatf("v%0d rd", idx), {27'b0, rd}, {27'b0, r[11:7]});
    check($sformatf("v%0d rs1", idx), {27'b0, rs1}, {27'b0, r[19:15]});
    check($sformatf("v%0d rs2/f3/f7", idx), {17'b0, rs2, funct3, funct7}, {17'b0, r[24:20], r[14:12], r[31:25]});
    @(negedge clk);
    check_bit($sformatf("v%0d inst_valid pulse end", idx), inst_valid, 1'b0);
  endtask

  // Random traffic compared each cycle against a transaction-level model.
  task automatic random_phase(input int cycles);
    logic        m_first, m_busy, m_req, m_valid, m_mis, m_ferr;
    logic [31:0] m_pc, m_preg, m_addr, m_ir, t;
    int          m_wait;
    m_first = 1'b1; m_busy = 1'b0; m_req = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_ferr = 1'b0;
    m_pc = RESET_PC; m_preg = 32'h0; m_addr = 32'h0; m_ir = NOP_INST; m_wait = 0;
    for (int c = 0; c < cycles; c++) begin
      check($sformatf("rnd%0d pc", c), pc, m_pc);
      check($sformatf("rnd%0d p_reg", c), p_reg, m_preg);
      check($sformatf("rnd%0d im_addr", c), im_addr, m_addr);
      check($sformatf("rnd%0d ir", c), ir, m_ir);
      check($sformatf("rnd%0d flags", c),
            {26'b0, im_req, fetch_busy, inst_valid, misalign_err, fetch_err, 1'b0},
            {26'b0, m_req, m_busy, m_valid, m_mis, m_ferr, 1'b0});
      ir_write      = ($urandom_range(0, 2) == 0);
      pc_write      = ($urandom_range(0, 3) != 0);
      pc_update_sel = 2'($urandom_range(0, 3));
      imm32         = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 1) == 1) imm32 = -imm32;
      if ($urandom_range(0, 9) == 0) imm32 = imm32 + 32'd2;
      f_reg         = $urandom;
      im_ack        = ($urandom_range(0, 2) != 0);
      im_rdata      = $urandom;
      m_valid = 1'b0;
      if (!m_busy) begin
        if (ir_write) begin
          if (m_first) t = RESET_PC;
          else if (!pc_write) t = m_pc;
          else if (pc_update_sel == SEL_JP_R) t = m_pc + imm32;
          else if (pc_update_sel == SEL_JP_F) t = f_reg & ~32'h1;
          else t = m_pc + 32'd4;
          if (t[1:0] != 2'b00) m_mis = 1'b1;
          t = t & ~32'h3;
          m_pc = t; m_preg = t + 32'd4; m_addr = t;
          m_req = 1'b1; m_busy = 1'b1; m_first = 1'b0; m_wait = 0;
        end
      end else if (im_ack) begin
        m_ir = im_rdata; m_req = 1'b0; m_busy = 1'b0; m_valid = 1'b1;
      end
`ifdef IF_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_ir = NOP_INST; m_ferr = 1'b1; m_req = 1'b0; m_busy = 1'b0; m_valid = 1'b1;
        end
      end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, SEL_STEP, 32'h0,        32'h0,        0, 32'h0050_0093, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, SEL_STEP, 32'h0,        32'h0,        1, 32'h00A0_0113, 32'h0000_0004, 1'b0};
    vecs[2]  = '{1'b0, SEL_JP_R, 32'h40,       32'h0,        2, 32'h0020_81B3, 32'h0000_0004, 1'b0};
    vecs[3]  = '{1'b1, SEL_JP_R, 32'h0000_000C, 32'h0,       0, 32'h4031_0233, 32'h0000_0010, 1'b0};
    vecs[4]  = '{1'b1, SEL_JP_R, 32'hFFFF_FFF8, 32'h0,       3, 32'h0081_22A3, 32'h0000_0008, 1'b0};
    vecs[5]  = '{1'b1, SEL_JP_F, 32'h0,        32'h0000_0101, 0, 32'h0000_0317, 32'h0000_0100, 1'b0};
    vecs[6]  = '{1'b1, SEL_JP_F, 32'h0,        32'h0000_0102, 1, 32'hFE52_9EE3, 32'h0000_0100, 1'b1};
    vecs[7]  = '{1'b1, 2'd3,     32'h0,        32'h0,        0, 32'h0040_00EF, 32'h0000_0104, 1'b1};
    vecs[8]  = '{1'b1, SEL_JP_F, 32'h0,        32'hFFFF_FFFC, 1, 32'h0000_8067, 32'hFFFF_FFFC, 1'b1};
    vecs[9]  = '{1'b1, SEL_STEP, 32'h0,        32'h0,        0, 32'h0012_8293, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, SEL_JP_R, 32'h0000_0006, 32'h0,       2, 32'h0073_0333, 32'h0000_0004, 1'b1};

    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("reset pc", pc, RESET_PC);
    check("reset p_reg", p_reg, 32'h0);
    check("reset ir", ir, NOP_INST);
    check("reset im_addr", im_addr, 32'h0);
    check("reset flags", {27'b0, im_req, fetch_busy, inst_valid, misalign_err, fetch_err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) apply_vector(vecs[i], i);

    // An ack while idle must not touch the IR or raise inst_valid.
    im_ack   = 1'b1;
    im_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    im_ack = 1'b0;
    check("idle ack ir", ir, vecs[10].rdata);
    check_bit("idle ack inst_valid", inst_valid, 1'b0);
    check_bit("idle ack im_req", im_req, 1'b0);

    // Reset in the middle of a wait drops the request at once and restarts at RESET_PC.
    ir_write      = 1'b1;
    pc_write      = 1'b1;
    pc_update_sel = SEL_JP_F;
    f_reg         = 32'h0000_0200;
    @(negedge clk);
    clear_inputs();
    check_bit("midwait im_req before reset", im_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("midwait reset im_req", im_req, 1'b0);
    check_bit("midwait reset busy", fetch_busy, 1'b0);
    check("midwait reset ir", ir, NOP_INST);
    check("midwait reset pc", pc, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
    apply_vector('{1'b1, SEL_STEP, 32'h0, 32'h0, 1, 32'h0050_0093, RESET_PC, 1'b0}, 20);

`ifdef IF_TIMEOUT_EN
    // No ack at all: the fetch is abandoned on the TIMEOUT-th wait cycle.
    do_reset();
    ir_write = 1'b1;
    @(negedge clk);
    ir_write = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    check_bit("timeout busy before limit", fetch_busy, 1'b1);
    @(negedge clk);
    check_bit("timeout fetch_err", fetch_err, 1'b1);
    check("timeout ir", ir, NOP_INST);
    check_bit("timeout busy", fetch_busy, 1'b0);
    check_bit("timeout inst_valid", inst_valid, 1'b1);
    check_bit("timeout im_req", im_req, 1'b0);

    // An ack on the TIMEOUT-th wait cycle still completes normally.
    do_reset();
    ir_write = 1'b1;
    @(negedge clk);
    ir_write = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    im_ack   = 1'b1;
    im_rdata = 32'h0031_0093;
    @(negedge clk);
    im_ack = 1'b0;
    check_bit("late ack fetch_err", fetch_err, 1'b0);
    check("late ack ir", ir, 32'h0031_0093);
    check_bit("late ack busy", fetch_busy, 1'b0);
`endif

    do_reset();
    random_phase(300);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
